// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: bundle between the scan sequencer and its surroundings.
//   start, continuous, ch_en : sweep control
//   sel, mux_y               : select to / word from the 16:1 multiplexer
//   out_data, out_ch,
//   out_valid, out_ready     : captured-word valid/ready port
//   busy, done               : status
// master = the sequencer, slave = the environment (mux + downstream).
interface mux_scan_ctrl_if;
    logic        start;
    logic        continuous;
    logic [15:0] ch_en;
    logic [3:0]  sel;
    logic [0:15] mux_y;
    logic [0:15] out_data;
    logic [3:0]  out_ch;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    modport master (
        input  start, continuous, ch_en, mux_y, out_ready,
        output sel, out_data, out_ch, out_valid, busy, done
    );

    modport slave (
        output start, continuous, ch_en, mux_y, out_ready,
        input  sel, out_data, out_ch, out_valid, busy, done
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: sweeps the enabled channels of a 16-channel multiplexer in
// ascending order, waits DWELL settle cycles per channel, captures the mux
// word plus its channel number and offers it on a valid/ready port.
// Single sweep or continuous repetition.
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : mux_scan_ctrl_if.master (control, mux select/data, output port,
//            busy/done status)
// Parameter DWELL: settle cycles per channel, 1..255.
module mux_scan_ctrl #(
    parameter int unsigned DWELL = 2
) (
    input logic             clk,
    input logic             rst_n,
    mux_scan_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        SETTLE,
        HOLD
    } state_t;

    localparam logic [7:0] DWELL_CNT = 8'(DWELL);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [3:0]  sel_q;
    logic [0:15] out_data_q;
    logic [3:0]  out_ch_q;
    logic        out_valid_q;
    logic        busy_q;
    logic        done_q;

    logic        last_ch;
    logic        sweep_end;

    assign last_ch = (sel_q == 4'hF);

    // Both ways a sweep can finish (disabled ch15 in SEEK, or the ch15
    // handshake in HOLD) are merged here so the wrap/restart logic exists once.
    assign sweep_end = last_ch &&
                       (((state_q == SEEK) && !bus.ch_en[sel_q]) ||
                        ((state_q == HOLD) && bus.out_ready));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        sel_q <= '0;
                        if (bus.ch_en != '0) begin
                            state_q <= SEEK;
                            busy_q  <= 1'b1;
                        end else begin
                            // Nothing to scan: report an empty sweep at once.
                            done_q <= 1'b1;
                        end
                    end
                end

                SEEK: begin
                    if (bus.ch_en[sel_q]) begin
                        state_q <= SETTLE;
                        cnt_q   <= DWELL_CNT;
                    end else if (!last_ch) begin
                        sel_q <= sel_q + 4'd1;
                    end
                end

                SETTLE: begin
                    if (cnt_q == 8'd1) begin
                        out_data_q  <= bus.mux_y;
                        out_ch_q    <= sel_q;
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= HOLD;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end

                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (!last_ch) begin
                            sel_q   <= sel_q + 4'd1;
                            state_q <= SEEK;
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase

            // Later non-blocking writes override the per-state ones above.
            if (sweep_end) begin
                done_q  <= 1'b1;
                sel_q   <= '0;
                state_q <= bus.continuous ? SEEK : IDLE;
                busy_q  <= bus.continuous;
            end
        end
    end

    assign bus.sel       = sel_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
module tb_mux_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] mux_base;
    int          checks;
    int          failures;

    mux_scan_ctrl_if bus ();

    mux_scan_ctrl #(.DWELL(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural multiplexer: word = base + selected channel.
    assign bus.mux_y = mux_base + {12'h000, bus.sel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until out_valid is seen or the budget expires; returns edges used.
    task automatic wait_valid(input int max_edges, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.out_valid && n < max_edges);
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.start      = 1'($urandom);
        bus.continuous = 1'($urandom);
        bus.ch_en      = 16'($urandom);
        bus.out_ready  = 1'($urandom);
        mux_base       = 16'($urandom);
        step();
        step();
        checks++;
        if (bus.sel !== 4'h0 || bus.out_ch !== 4'h0) begin
            failures++;
            $display("FAIL reset_sel_ch: sel=%h out_ch=%h expected 0 0", bus.sel, bus.out_ch);
        end
        checks++;
        if (bus.out_data !== 16'h0000 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out: data=%h valid=%b expected 0000 0", bus.out_data, bus.out_valid);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
        rst_n          = 1'b1;
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        bus.ch_en      = 16'h0000;
        bus.out_ready  = 1'b0;
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle: busy=%b done=%b expected 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_full_sweep();
        int words;
        int done_cnt;
        int done_edge;
        words     = 0;
        done_cnt  = 0;
        done_edge = -1;
        bus.ch_en      = 16'hFFFF;
        mux_base       = 16'hA000;
        bus.out_ready  = 1'b1;
        bus.continuous = 1'b0;
        bus.start      = 1'b1;
        step();                       // E0
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL full_busy_after_start: busy=%b expected 1", bus.busy);
        end
        for (int t = 1; t <= 100 && done_cnt == 0; t++) begin
            step();
            if (bus.out_valid) begin
                checks++;
                if (t != 3 + 4 * words || bus.out_ch !== 4'(words) ||
                    bus.out_data !== (16'hA000 + 16'(words))) begin
                    failures++;
                    $display("FAIL full_word%0d: edge=%0d ch=%h data=%h expected edge=%0d ch=%h data=%h",
                             words, t, bus.out_ch, bus.out_data, 3 + 4 * words,
                             4'(words), 16'hA000 + 16'(words));
                end
                words++;
            end
            if (bus.done) begin
                done_cnt++;
                done_edge = t;
                checks++;
                if (bus.busy !== 1'b0 || bus.sel !== 4'h0 || bus.out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL full_end_state: busy=%b sel=%h valid=%b expected 0 0 0",
                             bus.busy, bus.sel, bus.out_valid);
                end
            end
        end
        checks++;
        if (words != 16 || done_edge != 64) begin
            failures++;
            $display("FAIL full_totals: words=%0d done_edge=%0d expected 16 64", words, done_edge);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL full_done_pulse: done=%b busy=%b expected 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_sparse_backpressure();
        int n;
        logic [15:0] d;
        logic [3:0]  c;
        logic [3:0]  s;
        bus.ch_en     = 16'h8001;
        mux_base      = 16'h5A00;
        bus.out_ready = 1'b0;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        wait_valid(50, n);
        checks++;
        if (n != 3 || bus.out_ch !== 4'h0 || bus.out_data !== 16'h5A00) begin
            failures++;
            $display("FAIL sparse_word0: edges=%0d ch=%h data=%h expected 3 0 5a00", n, bus.out_ch, bus.out_data);
        end
        for (int w = 0; w < 2; w++) begin
            d = bus.out_data;
            c = bus.out_ch;
            s = bus.sel;
            for (int k = 0; k < 5; k++) begin
                step();
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== d || bus.out_ch !== c || bus.sel !== s) begin
                    failures++;
                    $display("FAIL sparse_stall_w%0d_c%0d: valid=%b data=%h ch=%h sel=%h expected 1 %h %h %h",
                             w, k, bus.out_valid, bus.out_data, bus.out_ch, bus.sel, d, c, s);
                end
            end
            bus.out_ready = 1'b1;
            step();
            bus.out_ready = 1'b0;
            if (w == 0) begin
                checks++;
                if (bus.out_valid !== 1'b0 || bus.sel !== 4'h1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                    failures++;
                    $display("FAIL sparse_hs0: valid=%b sel=%h busy=%b done=%b expected 0 1 1 0",
                             bus.out_valid, bus.sel, bus.busy, bus.done);
                end
                // 14 skipped channels + SEEK of ch15 + 2 SETTLE edges
                wait_valid(60, n);
                checks++;
                if (n != 17 || bus.out_ch !== 4'hF || bus.out_data !== 16'h5A0F) begin
                    failures++;
                    $display("FAIL sparse_word15: edges=%0d ch=%h data=%h expected 17 f 5a0f",
                             n, bus.out_ch, bus.out_data);
                end
            end else begin
                checks++;
                if (bus.done !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sel !== 4'h0) begin
                    failures++;
                    $display("FAIL sparse_end: done=%b valid=%b busy=%b sel=%h expected 1 0 0 0",
                             bus.done, bus.out_valid, bus.busy, bus.sel);
                end
            end
        end
    endtask

    task automatic test_empty_mask();
        bus.ch_en = 16'h0000;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        checks++;
        if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_start: done=%b busy=%b valid=%b expected 1 0 0", bus.done, bus.busy, bus.out_valid);
        end
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_after: done=%b busy=%b valid=%b expected 0 0 0", bus.done, bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_continuous();
        int done_cnt;
        int words;
        logic [3:0] prev_sel;
        done_cnt = 0;
        words    = 0;
        bus.ch_en      = 16'h8001;
        mux_base       = 16'h3300;
        bus.out_ready  = 1'b1;
        bus.continuous = 1'b1;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        for (int t = 0; t < 300 && done_cnt < 3; t++) begin
            prev_sel = bus.sel;
            step();
            if (bus.out_valid) words++;
            if (bus.done) begin
                done_cnt++;
                checks++;
                if (prev_sel !== 4'hF || bus.sel !== 4'h0 || bus.busy !== (done_cnt < 3)) begin
                    failures++;
                    $display("FAIL cont_end%0d: prev_sel=%h sel=%h busy=%b expected f 0 %b",
                             done_cnt, prev_sel, bus.sel, bus.busy, done_cnt < 3);
                end
                if (done_cnt == 2) bus.continuous = 1'b0;
            end
        end
        checks++;
        if (done_cnt != 3 || words != 6) begin
            failures++;
            $display("FAIL cont_totals: dones=%0d words=%0d expected 3 6", done_cnt, words);
        end
        step();
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL cont_idle: busy=%b done=%b valid=%b expected 0 0 0", bus.busy, bus.done, bus.out_valid);
        end
    endtask

    task automatic test_abort();
        int n;
        int t;
        bus.ch_en     = 16'hFFFF;
        mux_base      = 16'h7700;
        bus.out_ready = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        t = 0;
        while (!(bus.out_valid && bus.out_ch == 4'h7) && t < 100) begin
            step();
            t++;
        end
        bus.out_ready = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_ch !== 4'h7 || bus.sel !== 4'h7) begin
            failures++;
            $display("FAIL abort_hold7: valid=%b ch=%h sel=%h expected 1 7 7", bus.out_valid, bus.out_ch, bus.sel);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.sel !== 4'h0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset: valid=%b sel=%h done=%b busy=%b expected 0 0 0 0",
                     bus.out_valid, bus.sel, bus.done, bus.busy);
        end
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_after: done=%b busy=%b expected 0 0", bus.done, bus.busy);
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        wait_valid(50, n);
        checks++;
        if (n != 3 || bus.out_ch !== 4'h0 || bus.out_data !== 16'h7700) begin
            failures++;
            $display("FAIL abort_restart: edges=%0d ch=%h data=%h expected 3 0 7700", n, bus.out_ch, bus.out_data);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.continuous = 1'b0;
        bus.ch_en      = 16'h0000;
        bus.out_ready  = 1'b0;
        mux_base       = 16'h0000;
        test_reset();
        test_full_sweep();
        test_sparse_backpressure();
        test_empty_mask();
        test_continuous();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
